// File: rtl/parity_mem.sv
// parity_mem: small clocked memory that stores a parity bit with every word.
//
// Parity is generated on write and checked on every registered read. Error
// status comes out as a per-read flag, a sticky flag, the address of the
// first failing read since the last clear, and a saturating error counter.
// inj_err corrupts the stored parity on a write so the checker can be tested.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-high reset
//   wr_en_i      write strobe
//   wr_addr_i    write address
//   wr_data_i    write data
//   inj_err_i    invert the stored parity bit of this write
//   rd_en_i      read strobe
//   rd_addr_i    read address
//   clr_err_i    clear err_cnt_o / err_sticky_o / err_addr_o at the edge
//   rd_data_o    registered read data, held while no read is issued
//   rd_valid_o   one-cycle pulse, one cycle after rd_en_i
//   par_err_o    parity mismatch for the current rd_data_o (only with rd_valid_o)
//   err_sticky_o any parity error since the last clear
//   err_addr_o   address of the first error since the last clear
//   err_cnt_o    saturating parity error count
module parity_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned ODD    = 0,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              inj_err_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              clr_err_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              par_err_o,
  output logic              err_sticky_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int unsigned Depth = 1 << ADDR_W;
  // Parity of an all-zero word: 0 for even parity, 1 for odd parity.
  localparam logic ResetPar = (ODD != 0);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  function automatic logic gen_parity(input logic [DATA_W-1:0] data);
    return (ODD != 0) ? ~^data : ^data;
  endfunction

  // Storage: bit DATA_W is the parity bit, the rest is data.
  logic [DATA_W:0] mem_q [Depth];

  logic [DATA_W:0]   rd_word;
  logic              err_det;

  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_valid_d, rd_valid_q;
  logic              par_err_d, par_err_q;
  logic              err_sticky_d, err_sticky_q;
  logic [ADDR_W-1:0] err_addr_d, err_addr_q;
  logic [CNT_W-1:0]  err_cnt_d, err_cnt_q;

  // Read sees the array before this edge's write lands: read-before-write.
  assign rd_word = mem_q[rd_addr_i];
  assign err_det = rd_en_i & (rd_word[DATA_W] != gen_parity(rd_word[DATA_W-1:0]));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= {ResetPar, {DATA_W{1'b0}}};
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= {gen_parity(wr_data_i) ^ inj_err_i, wr_data_i};
    end
  end

  always_comb begin
    rd_valid_d = rd_en_i;
    par_err_d  = err_det;
    rd_data_d  = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = rd_word[DATA_W-1:0];
    end
  end

  // A clear on the same edge as a detected error restarts bookkeeping with
  // that error as the first one.
  always_comb begin
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    err_addr_d   = err_addr_q;
    if (clr_err_i) begin
      err_cnt_d    = err_det ? CNT_W'(1) : '0;
      err_sticky_d = err_det;
      err_addr_d   = err_det ? rd_addr_i : '0;
    end else if (err_det) begin
      if (err_cnt_q != CntMax) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      err_sticky_d = 1'b1;
      if (!err_sticky_q) begin
        err_addr_d = rd_addr_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      par_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_addr_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      par_err_q    <= par_err_d;
      err_sticky_q <= err_sticky_d;
      err_addr_q   <= err_addr_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign par_err_o    = par_err_q;
  assign err_sticky_o = err_sticky_q;
  assign err_addr_o   = err_addr_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_parity_mem.sv
// Scoreboard bench for parity_mem. A driver issues one cycle of stimulus at a
// time, updates a word-level model (data plus a "corrupted" flag per entry and
// error bookkeeping) and queues the expected result of every read; a monitor
// pops and compares whenever rd_valid_o is seen.
module tb_parity_mem;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       inj_err;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       par_err;
  logic       err_sticky;
  logic [2:0] err_addr;
  logic [3:0] err_cnt;

  parity_mem #(
    .DATA_W(8),
    .ADDR_W(3),
    .ODD   (0),
    .CNT_W (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .inj_err_i   (inj_err),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .clr_err_i   (clr_err),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .par_err_o   (par_err),
    .err_sticky_o(err_sticky),
    .err_addr_o  (err_addr),
    .err_cnt_o   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       sticky;
    logic [2:0] addr;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model
  logic [7:0] m_data[8];
  bit         m_bad[8];
  int         m_cnt;
  bit         m_sticky;
  int         m_addr;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_data[i] = 8'h00;
      m_bad[i]  = 1'b0;
    end
    m_cnt    = 0;
    m_sticky = 1'b0;
    m_addr   = 0;
  endtask

  task automatic drive_idle();
    wr_en = 0; wr_addr = 0; wr_data = 0; inj_err = 0;
    rd_en = 0; rd_addr = 0; clr_err = 0;
  endtask

  // One clock of stimulus, applied just after the falling edge.
  task automatic cycle(input bit we, input int wa, input logic [7:0] wd, input bit inj,
                       input bit re, input int ra, input bit clr);
    bit         det;
    logic [7:0] old;
    exp_t       e;
    @(negedge clk);
    #1;
    wr_en = we; wr_addr = 3'(wa); wr_data = wd; inj_err = inj;
    rd_en = re; rd_addr = 3'(ra); clr_err = clr;
    det = re && m_bad[ra];
    old = m_data[ra];
    if (clr) begin
      m_cnt    = det ? 1 : 0;
      m_sticky = det;
      m_addr   = det ? ra : 0;
    end else if (det) begin
      if (!m_sticky) m_addr = ra;
      m_cnt    = (m_cnt < 15) ? m_cnt + 1 : 15;
      m_sticky = 1'b1;
    end
    if (re) begin
      e.data = old; e.perr = det; e.sticky = m_sticky;
      e.addr = 3'(m_addr); e.cnt = 4'(m_cnt);
      sb.push_back(e);
    end
    if (we) begin
      m_data[wa] = wd;
      m_bad[wa]  = inj;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_par_err", par_err, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_err_addr", err_addr, 0);
    #1;
    rst = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      chk("par_err_gated", par_err & ~rd_valid, 0);
      if (rd_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rd_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_data", rd_data, e.data);
          chk("par_err", par_err, e.perr);
          chk("err_sticky", err_sticky, e.sticky);
          chk("err_addr", err_addr, e.addr);
          chk("err_cnt", err_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    do_reset();

    // Reset contents
    for (int a = 0; a < 8; a++) cycle(0, 0, 8'h00, 0, 1, a, 0);
    // Write then back-to-back reads
    cycle(1, 0, 8'h1B, 0, 0, 0, 0);
    cycle(1, 1, 8'h07, 0, 0, 0, 0);
    cycle(0, 0, 8'h00, 0, 1, 0, 0);
    cycle(0, 0, 8'h00, 0, 1, 1, 0);
    // Read-before-write
    cycle(1, 2, 8'h30, 0, 0, 0, 0);
    cycle(1, 2, 8'hFF, 0, 1, 2, 0);
    cycle(0, 0, 8'h00, 0, 1, 2, 0);
    // Injection; inj_err without wr_en must do nothing
    cycle(0, 4, 8'h00, 1, 0, 0, 0);
    cycle(1, 5, 8'h1B, 1, 1, 4, 0);
    cycle(0, 0, 8'h00, 0, 1, 5, 0);
    cycle(1, 3, 8'h5A, 1, 0, 0, 0);
    cycle(0, 0, 8'h00, 0, 1, 3, 0);
    // Saturation then clears
    for (int i = 0; i < 20; i++) cycle(0, 0, 8'h00, 0, 1, 3, 0);
    cycle(0, 0, 8'h00, 0, 0, 0, 1);
    cycle(0, 0, 8'h00, 0, 1, 0, 0);
    cycle(0, 0, 8'h00, 0, 1, 3, 1);
    cycle(0, 0, 8'h00, 0, 1, 5, 0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, 7), 8'($urandom), $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 19) == 0);
    end
    idle(2);

    // Async reset while a read is in flight
    cycle(1, 2, 8'hA5, 1, 0, 0, 0);
    cycle(0, 0, 8'h00, 0, 1, 2, 0);
    cycle(0, 0, 8'h00, 0, 1, 2, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("async_rd_valid", rd_valid, 0);
    chk("async_par_err", par_err, 0);
    chk("async_rd_data", rd_data, 0);
    chk("async_err_cnt", err_cnt, 0);
    chk("async_err_sticky", err_sticky, 0);
    drive_idle();
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 8; a++) cycle(0, 0, 8'h00, 0, 1, a, 0);
    idle(3);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_mem.md
# parity_mem

Parametrised, clocked, writable memory with stored parity. It generates a parity bit on every write, checks it on every registered read, and keeps error status: a per-read error flag, a sticky flag, the address of the first failing read, and a saturating error counter. It sits wherever the lab datapath needs a small lookup or scratch store with integrity checking. An error-injection input lets the bench and system self-test corrupt stored parity on purpose.

## Interface
- DATA_W, 8, data bits per word
- ADDR_W, 3, address bits; depth = 2**ADDR_W
- ODD, 0, 0 = even parity (stored bit = ^data), 1 = odd parity (stored bit = ~^data)
- CNT_W, 4, error counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- inj_err  in  1  when set together with wr_en, the stored parity bit is inverted
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  read address
- clr_err  in  1  clears err_cnt, err_sticky and err_addr
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse, one cycle after rd_en
- par_err  out  1  parity mismatch for the current rd_data; only ever high when rd_valid is high
- err_sticky  out  1  set by any parity error, held until clr_err
- err_addr  out  ADDR_W  address of the first error since the last clear
- err_cnt  out  CNT_W  count of parity errors, saturating

## Operation
- Storage is depth x (DATA_W+1). Each entry holds the data and its parity bit.
- Reset (async, active-high):
  - Every entry is set to data 0 with the correct parity for 0 (0 if ODD=0, 1 if ODD=1).
  - All outputs go to 0: rd_data, rd_valid, par_err, err_sticky, err_addr, err_cnt.
- Write: when wr_en=1, entry[wr_addr] <= {gen_parity(wr_data) ^ inj_err, wr_data}.
- Read: when rd_en=1, the block registers:
  - rd_data <= entry[rd_addr].data
  - rd_valid <= 1
  - par_err <= (stored parity != gen_parity(stored data))
- When rd_en=0: rd_valid <= 0, par_err <= 0, and rd_data holds its last value.
- Error bookkeeping on the same edge that par_err is registered high:
  - err_cnt increments and saturates at 2**CNT_W-1 (never wraps).
  - err_sticky <= 1.
  - err_addr <= rd_addr, only if err_sticky was 0 (first error only).
- clr_err takes effect at the clock edge.
  - If an error is detected on the same edge: err_cnt=1, err_sticky=1, err_addr=that rd_addr.
  - Otherwise: err_cnt=0, err_sticky=0, err_addr=0.
- Read and write to the same address on the same edge: read-before-write. The read returns the old word; the new word is visible to the next read.
- Reads and writes to different addresses are independent and may occur in the same cycle.
- inj_err without wr_en has no effect.

## Timing
- Write latency: data is stored at edge N and is readable by a read issued at edge N+1.
- Read latency: rd_en sampled at edge N gives rd_data/rd_valid/par_err valid after edge N, for one cycle. The result is held until the next edge.
- Back-to-back reads give one result per cycle with no bubbles.
- Status outputs (err_*) update on the same edge as the par_err they record.
- rst asserted mid-operation clears everything immediately, with no clock needed. An in-flight read produces no rd_valid.
- No combinational path from any input to any output.

## Test plan
- Reset check: assert rst, then read all 8 addresses (ODD=0) -> rd_data=8'h00, par_err=0 each, err_cnt=0.
- Write/read: write 8'h1B to addr 0 and 8'h07 to addr 1, then read 0 and 1 back-to-back -> rd_data 8'h1B then 8'h07 on consecutive cycles, rd_valid high for two cycles, par_err=0.
- Read-before-write: write 8'h30 to addr 2, then on the same edge write 8'hFF to addr 2 and read addr 2 -> 8'h30; the next read of addr 2 -> 8'hFF.
- Injection:
  - Write 8'h1B to addr 5 with inj_err=1, then read addr 5 -> par_err=1, err_sticky=1, err_addr=5, err_cnt=1.
  - Then corrupt addr 3 and read it -> err_addr stays 5, err_cnt=2.
- Saturation/clear:
  - With CNT_W=4, do 20 erroneous reads -> err_cnt=15.
  - Then clr_err with no error -> err_cnt=0, err_sticky=0, err_addr=0.
  - Then clr_err coincident with an erroneous read of addr 3 -> err_cnt=1, err_addr=3.
- Async reset mid-read: assert rst between edges right after rd_en was sampled -> rd_valid=0 immediately, and all entries read back 0 with correct parity.
